clock_monitor: RTL



---
 rtl/clock_monitor_pkg.sv | 27 ++
 rtl/clock_monitor_edge_sync.sv | 33 +++
 rtl/clock_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared types, default parameters and helpers for the clock monitor.
package clock_monitor_pkg;

  localparam int unsigned DEF_HALF_PERIOD = 5;
  localparam int unsigned DEF_TOLERANCE   = 0;
  localparam int unsigned DEF_LOCK_COUNT  = 4;
  localparam int unsigned DEF_TIMEOUT     = 16;
  localparam int unsigned DEF_CNT_W       = 5;

  // Monitor state encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } mon_state_e;

  // Absolute-difference tolerance test, unsigned with no wrap.
  function automatic logic within_tol(input int unsigned meas,
                                      input int unsigned nominal,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (meas >= nominal) ? (meas - nominal) : (nominal - meas);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/clock_monitor_edge_sync.sv
// Two-flop synchroniser plus a history flop with rise/fall decode.
module edge_sync (
  input  logic i_clk50mhz,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchroniser chain; sync3 holds the previous synchronised level.
  always_ff @(posedge i_clk50mhz) begin
    if (!i_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= i_async;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Edge decode straight off the flop chain; consumers register it.
  assign o_level = sync2;
  assign o_rise  = sync2 & ~sync3;
  assign o_fall  = ~sync2 & sync3;

endmodule

// File: rtl/clock_monitor.sv
// Measures every half-period of a monitored clock in system-clock cycles
// and reports edge strobes, the last measurement, lock and sticky fault.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int unsigned TOLERANCE   = DEF_TOLERANCE,
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             i_clk50mhz,
  input  logic             i_rst_n,
  input  logic             i_clk_mon,
  input  logic             i_fault_clr,
  output logic             o_edge_rise,
  output logic             o_edge_fall,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_locked,
  output logic             o_fault
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  logic               mon_level;
  logic               mon_rise;
  logic               mon_fall;
  logic               edge_c;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   meas_c;
  logic               in_tol_c;
  logic               timeout_c;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_inc_c;
  logic               lock_hit_c;
  mon_state_e         state;

  edge_sync u_edge_sync (
    .i_clk50mhz (i_clk50mhz),
    .i_rst_n    (i_rst_n),
    .i_async    (i_clk_mon),
    .o_level    (mon_level),
    .o_rise     (mon_rise),
    .o_fall     (mon_fall)
  );

  // Edge detect, measurement and timeout qualifiers.
  always_comb begin
    edge_c      = mon_rise | mon_fall;
    meas_c      = (cnt == CNT_ONES) ? cnt : (cnt + CNT_W'(1));
    in_tol_c    = within_tol(32'(meas_c), HALF_PERIOD, TOLERANCE);
    timeout_c   = !edge_c && (cnt == CNT_TO);
    match_inc_c = match + MATCH_W'(1);
    lock_hit_c  = ((32'(match) + 32'd1) == LOCK_COUNT);
  end

  // Cycles since the last edge, saturating at the timeout value.
  always_ff @(posedge i_clk50mhz) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (edge_c) begin
      cnt <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Monitor FSM with registered strobes, measurement and status outputs.
  always_ff @(posedge i_clk50mhz) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      match         <= '0;
      o_edge_rise   <= 1'b0;
      o_edge_fall   <= 1'b0;
      o_valid       <= 1'b0;
      o_half_period <= '0;
      o_locked      <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      o_edge_rise <= edge_c & mon_level;
      o_edge_fall <= edge_c & ~mon_level;
      o_valid     <= edge_c && (state != ST_IDLE);
      if (edge_c && (state != ST_IDLE)) begin
        o_half_period <= meas_c;
      end

      if (i_fault_clr) begin
        state    <= ST_IDLE;
        match    <= '0;
        o_locked <= 1'b0;
        o_fault  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // First edge only starts measurement; its length is meaningless.
            if (edge_c) begin
              state <= ST_ACQ;
              match <= '0;
            end
          end
          ST_ACQ: begin
            if (edge_c) begin
              if (in_tol_c) begin
                match <= match_inc_c;
                if (lock_hit_c) begin
                  state    <= ST_LOCK;
                  o_locked <= 1'b1;
                end
              end else begin
                match <= '0;
              end
            end else if (timeout_c) begin
              state   <= ST_FAULT;
              o_fault <= 1'b1;
            end
          end
          ST_LOCK: begin
            if ((edge_c && !in_tol_c) || timeout_c) begin
              state    <= ST_FAULT;
              o_locked <= 1'b0;
              o_fault  <= 1'b1;
            end
          end
          ST_FAULT: begin
            // Sticky until cleared.
          end
          default: begin
            state    <= ST_IDLE;
            match    <= '0;
            o_locked <= 1'b0;
            o_fault  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
